// File: rtl/dds_phase_accumulator.sv
// Numerically controlled oscillator: a tuning word is integrated into a wide phase accumulator on each sample tick.
// The tuning word can glide linearly toward a new target (portamento), and a hard-sync input clears the accumulator.
//
// state | meaning
// IDLE  | cur_tw == target == 0; accumulator frozen
// RUN   | cur_tw == target != 0
// GLIDE | cur_tw stepping toward target; new tuning words held off
module dds_phase_accumulator #(
    parameter int n     = 14,
    parameter int ACC_W = 24,
    parameter int TW_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [TW_W-1:0] tw_in,
    input  logic            tw_valid,
    output logic            tw_ready,
    input  logic [TW_W-1:0] glide_rate,
    input  logic            sync,
    output logic [n-1:0]    phase,
    output logic            wrap,
    output logic [TW_W-1:0] cur_tw,
    output logic            gliding
);

    localparam int EXT_W = ACC_W + 1 - TW_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GLIDE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [TW_W-1:0]  cur_tw_q, cur_tw_d;
    logic [TW_W-1:0]  target_q, target_d;
    logic             wrap_q, wrap_d;

    logic             accept;
    logic [ACC_W:0]   sum;
    logic [TW_W-1:0]  diff;
    logic             target_above;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cur_tw_q <= '0;
            target_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cur_tw_q <= cur_tw_d;
            target_q <= target_d;
            wrap_q   <= wrap_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cur_tw_d     = cur_tw_q;
        target_d     = target_q;
        wrap_d       = 1'b0;
        accept       = tw_valid && (state_q != ST_GLIDE);
        sum          = {1'b0, acc_q} + {{EXT_W{1'b0}}, cur_tw_q};
        target_above = (target_q > cur_tw_q);
        diff         = target_above ? (target_q - cur_tw_q) : (cur_tw_q - target_q);

        // The add always uses the tuning word held before this edge's glide/accept update.
        if (tick) begin
            acc_d  = sum[ACC_W-1:0];
            wrap_d = sum[ACC_W];
        end
        if (sync) begin
            acc_d  = '0;
            wrap_d = 1'b0;
        end

        // Accept and glide step are mutually exclusive: tw_ready is low throughout GLIDE.
        if (tick && (state_q == ST_GLIDE)) begin
            if (diff <= glide_rate) begin
                cur_tw_d = target_q;
                state_d  = (target_q == '0) ? ST_IDLE : ST_RUN;
            end else if (target_above) begin
                cur_tw_d = cur_tw_q + glide_rate;
            end else begin
                cur_tw_d = cur_tw_q - glide_rate;
            end
        end else if (accept) begin
            target_d = tw_in;
            if (glide_rate == '0) begin
                cur_tw_d = tw_in;
                state_d  = (tw_in == '0) ? ST_IDLE : ST_RUN;
            end else if (tw_in != cur_tw_q) begin
                state_d = ST_GLIDE;
            end
        end
    end

    assign phase    = acc_q[ACC_W-1 -: n];
    assign wrap     = wrap_q;
    assign cur_tw   = cur_tw_q;
    assign gliding  = (state_q == ST_GLIDE);
    assign tw_ready = (state_q != ST_GLIDE);

endmodule
